// File: rtl/alu_op_sequencer.sv
// Issue/collect sequencer for the 32-bit combinational ALU: decodes one request,
// drives registered ALU operands, captures the result and returns a response.
module alu_op_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_opcode,
   input  logic [5:0]  req_funct,
   input  logic [31:0] req_rs,
   input  logic [31:0] req_rt,
   input  logic [15:0] req_imm,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        resp_zero,
   output logic        resp_branch_taken,
   output logic        resp_illegal
);

   typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0100;
   localparam logic [3:0] CTRL_SLT = 4'b1000;

   state_t      state;
   logic        is_beq, is_bne;

   logic        dec_legal;
   logic [3:0]  dec_ctrl;
   logic [31:0] dec_b;
   logic        dec_beq, dec_bne;
   logic [31:0] imm_sext, imm_zext;

   assign imm_sext = {{16{req_imm[15]}}, req_imm};
   assign imm_zext = {16'h0000, req_imm};

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      dec_legal = 1'b1;
      dec_ctrl  = CTRL_AND;
      dec_b     = req_rt;
      dec_beq   = 1'b0;
      dec_bne   = 1'b0;
      case (req_opcode)
         6'b000000: begin
            case (req_funct)
               6'b100100: dec_ctrl = CTRL_AND;
               6'b100101: dec_ctrl = CTRL_OR;
               6'b100000: dec_ctrl = CTRL_ADD;
               6'b100010: dec_ctrl = CTRL_SUB;
               6'b101010: dec_ctrl = CTRL_SLT;
               default:   dec_legal = 1'b0;
            endcase
         end
         6'b001000: begin dec_ctrl = CTRL_ADD; dec_b = imm_sext; end
         6'b001010: begin dec_ctrl = CTRL_SLT; dec_b = imm_sext; end
         6'b001100: begin dec_ctrl = CTRL_AND; dec_b = imm_zext; end
         6'b001101: begin dec_ctrl = CTRL_OR;  dec_b = imm_zext; end
         6'b100011,
         6'b101011: begin dec_ctrl = CTRL_ADD; dec_b = imm_sext; end
         6'b000100: begin dec_ctrl = CTRL_SUB; dec_beq = 1'b1; end
         6'b000101: begin dec_ctrl = CTRL_SUB; dec_bne = 1'b1; end
         default:   dec_legal = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         req_ready         <= 1'b1;
         resp_valid        <= 1'b0;
         resp_result       <= '0;
         resp_zero         <= 1'b0;
         resp_branch_taken <= 1'b0;
         resp_illegal      <= 1'b0;
         alu_a             <= '0;
         alu_b             <= '0;
         alu_ctrl          <= CTRL_AND;
         is_beq            <= 1'b0;
         is_bne            <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  is_beq    <= dec_beq;
                  is_bne    <= dec_bne;
                  if (dec_legal) begin
                     alu_a    <= req_rs;
                     alu_b    <= dec_b;
                     alu_ctrl <= dec_ctrl;
                     state    <= DRIVE;
                  end else begin
                     // Illegal ops skip the ALU entirely and leave its inputs untouched.
                     resp_result       <= '0;
                     resp_zero         <= 1'b0;
                     resp_branch_taken <= 1'b0;
                     resp_illegal      <= 1'b1;
                     resp_valid        <= 1'b1;
                     state             <= RESP;
                  end
               end
            end
            DRIVE: state <= CAPTURE;
            CAPTURE: begin
               resp_result       <= alu_result;
               resp_zero         <= alu_zero;
               resp_branch_taken <= (is_beq & alu_zero) | (is_bne & ~alu_zero);
               resp_illegal      <= 1'b0;
               resp_valid        <= 1'b1;
               state             <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer against an instruction-level
// reference model; includes a behavioural ALU as the environment.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_opcode = '0;
   logic [5:0]  req_funct = '0;
   logic [31:0] req_rs = '0;
   logic [31:0] req_rt = '0;
   logic [15:0] req_imm = '0;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_result;
   logic        resp_zero, resp_branch_taken, resp_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_funct(req_funct),
      .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_zero(resp_zero),
      .resp_branch_taken(resp_branch_taken), .resp_illegal(resp_illegal)
   );

   // Datapath ALU the block is meant to drive (unsigned SLT).
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0100: alu_result = alu_a - alu_b;
         4'b1000: alu_result = {31'd0, alu_a < alu_b};
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == 32'd0);

   typedef struct {
      logic        legal;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        taken;
   } exp_t;

   logic [31:0] prev_a = '0, prev_b = '0;
   logic [3:0]  prev_ctrl = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Instruction-level meaning of each request.
   function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [15:0] imm);
      exp_t e;
      logic [31:0] se, ze;
      se = {{16{imm[15]}}, imm};
      ze = {16'h0, imm};
      e.legal = 1'b1; e.a = rs; e.b = rt; e.ctrl = 4'b0000; e.res = '0; e.taken = 1'b0;
      case (op)
         6'd0: case (fn)
            6'b100100: begin e.ctrl = 4'b0000; e.res = rs & rt; end
            6'b100101: begin e.ctrl = 4'b0001; e.res = rs | rt; end
            6'b100000: begin e.ctrl = 4'b0010; e.res = rs + rt; end
            6'b100010: begin e.ctrl = 4'b0100; e.res = rs - rt; end
            6'b101010: begin e.ctrl = 4'b1000; e.res = (rs < rt) ? 32'd1 : 32'd0; end
            default:   e.legal = 1'b0;
         endcase
         6'b001000, 6'b100011, 6'b101011: begin e.ctrl = 4'b0010; e.b = se; e.res = rs + se; end
         6'b001010: begin e.ctrl = 4'b1000; e.b = se; e.res = (rs < se) ? 32'd1 : 32'd0; end
         6'b001100: begin e.ctrl = 4'b0000; e.b = ze; e.res = rs & ze; end
         6'b001101: begin e.ctrl = 4'b0001; e.b = ze; e.res = rs | ze; end
         6'b000100: begin e.ctrl = 4'b0100; e.res = rs - rt; e.taken = (rs == rt); end
         6'b000101: begin e.ctrl = 4'b0100; e.res = rs - rt; e.taken = (rs != rt); end
         default:   e.legal = 1'b0;
      endcase
      if (!e.legal) e.res = '0;
      e.zero = e.legal && (e.res == 32'd0);
      return e;
   endfunction

   // Present a request and return #1 after its accept edge, with req_valid dropped.
   task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm);
      int k = 0;
      req_opcode = op; req_funct = fn; req_rs = rs; req_rt = rt; req_imm = imm;
      req_valid = 1'b1;
      while (!req_ready && k < 20) begin
         @(posedge clk); #1; k++;
      end
      check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Checks everything from the accept edge through the response handshake.
   task automatic post_accept(input exp_t e, input int hold);
      if (e.legal) begin
         check("alu_a", alu_a, e.a);
         check("alu_b", alu_b, e.b);
         check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
         check("resp_valid_n0", {31'd0, resp_valid}, 32'd0);
         check("req_ready_drive", {31'd0, req_ready}, 32'd0);
         @(posedge clk); #1;
         check("resp_valid_n1", {31'd0, resp_valid}, 32'd0);
         @(posedge clk); #1;
         prev_a = e.a; prev_b = e.b; prev_ctrl = e.ctrl;
      end else begin
         check("illegal_alu_ctrl_kept", {28'd0, alu_ctrl}, {28'd0, prev_ctrl});
         check("illegal_alu_a_kept", alu_a, prev_a);
      end
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_result", resp_result, e.res);
      check("resp_zero", {31'd0, resp_zero}, {31'd0, e.zero});
      check("resp_taken", {31'd0, resp_branch_taken}, {31'd0, e.taken});
      check("resp_illegal", {31'd0, resp_illegal}, {31'd0, ~e.legal});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
         check("hold_resp_result", resp_result, e.res);
         check("hold_req_ready", {31'd0, req_ready}, 32'd0);
         check("hold_alu_a", alu_a, prev_a);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("resp_valid_done", {31'd0, resp_valid}, 32'd0);
      check("req_ready_done", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic run_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm, input int hold);
      send(op, fn, rs, rt, imm);
      post_accept(model(op, fn, rs, rt, imm), hold);
   endtask

   logic [5:0] op_tbl [13] = '{6'd0, 6'd0, 6'd0, 6'b001000, 6'b001010, 6'b001100, 6'b001101,
                               6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b111111};
   logic [5:0] fn_tbl [6]  = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b000111};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_result", resp_result, 32'd0);
      check("rst_resp_flags", {29'd0, resp_zero, resp_branch_taken, resp_illegal}, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(6'd0, 6'b100000, 32'd5, 32'd7, 16'h0, 0);
      run_op(6'b000100, 6'd0, 32'h1234, 32'h1234, 16'h0, 0);
      run_op(6'b000101, 6'd0, 32'h1234, 32'h1234, 16'h0, 0);
      run_op(6'b001100, 6'd0, 32'hFFFF00FF, 32'd0, 16'h8F0F, 0);
      run_op(6'b001000, 6'd0, 32'd1, 32'd0, 16'hFFFF, 0);
      run_op(6'b000010, 6'd0, 32'd3, 32'd4, 16'h0, 0);

      // Backpressure with a second request waiting the whole time.
      send(6'd0, 6'b100101, 32'hA0A0_0000, 32'h0000_0505, 16'h0);
      req_opcode = 6'd0; req_funct = 6'b100010; req_rs = 32'd100; req_rt = 32'd42;
      req_valid = 1'b1;
      post_accept(model(6'd0, 6'b100101, 32'hA0A0_0000, 32'h0000_0505, 16'h0), 5);
      @(posedge clk); #1;
      req_valid = 1'b0;
      post_accept(model(6'd0, 6'b100010, 32'd100, 32'd42, 16'h0), 0);

      // Reset while SUB sits in CAPTURE: no response may appear.
      send(6'd0, 6'b100010, 32'd9, 32'd9, 16'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      prev_a = '0; prev_b = '0; prev_ctrl = '0;
      check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("mid_rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      check("mid_rst_resp_zero", {31'd0, resp_zero}, 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      run_op(6'd0, 6'b100000, 32'd20, 32'd22, 16'h0, 0);

      for (int i = 0; i < 60; i++) begin
         logic [5:0]  op, fn;
         logic [31:0] rs, rt;
         op = op_tbl[$urandom_range(12)];
         fn = (op == 6'd0) ? fn_tbl[$urandom_range(5)] : 6'($urandom);
         rs = $urandom;
         rt = ($urandom_range(3) == 0) ? rs : $urandom;
         run_op(op, fn, rs, rt, 16'($urandom), int'($urandom_range(3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
